fp_compare_pipe: RTL and testbench
==================================

Name: fp_compare_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point comparator for the CORDIC datapath.
- Compares two operands of configurable exponent/mantissa width.
- Returns the full ordering (lt/eq/gt), an op-selected boolean, and the max/min operand.
- Streams through a 2-stage valid/ready pipeline with full backpressure, so angle-range checks and quadrant selection can run back-to-back at one compare per clock.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; total width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of user tag carried alongside each compare.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_op  in  3  0=GT, 1=GE, 2=LT, 3=LE, 4=EQ, 5=NE, 6=MAX, 7=MIN.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_lt  out  1  A < B.
- out_eq  out  1  A == B.
- out_gt  out  1  A > B.
- out_res  out  1  boolean for in_op 0-5; for 6/7, 1 when A is selected.
- out_sel  out  W  MAX: larger operand; MIN: smaller operand; ops 0-5: in_a.
- out_unord  out  1  unordered (NaN present); 0 when feature absent.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: asynchronous assert on rst_n low, synchronous release.
  - All stage valids 0, so out_valid=0.
  - out_lt/eq/gt/res/unord=0; out_sel=0; out_tag=0.
  - in_ready=1 one cycle after release.
- Reset mid-operation: in-flight results are discarded, not delivered.
- Stage 1, registered on accept (in_valid & in_ready):
  - Split sign/exponent/mantissa of each operand.
  - zero_x = exponent and mantissa both 0.
  - Unsigned magnitude compare of {exp,man}: mag_gt, mag_eq.
  - Latch op, tag, and both operands.
- Stage 2, registered outputs:
  - Both operands zero: eq=1 (+0 == -0).
  - Signs differ: positive operand is greater.
  - Both positive: gt=mag_gt, eq=mag_eq.
  - Both negative: gt = ~mag_gt & ~mag_eq, eq=mag_eq.
  - lt = ~gt & ~eq.
  - Exactly one of lt/eq/gt is set when ordered.
  - Denormals compare by raw magnitude; no flushing.
  - Infinities order naturally.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays 1. Throughput 1/clk.
- Handshake:
  - A stage advances when empty or when its successor advances.
  - in_ready = ~s1_valid | s2_adv, where s2_adv = ~s2_valid | out_ready. in_ready is combinational from out_ready and has no skid buffer.
  - Output holds all fields stable while out_valid & ~out_ready.
  - Simultaneous accept and drain in the same cycle: no bubble, no loss.
- MAX/MIN tie (eq=1): selects in_a, and out_res=1. For ±0 this returns A's sign.
- Output ordering is strictly FIFO; tags are returned in input order.

Optional Feature:
- Macro FP_CMP_NAN_EN.
- When defined:
  - Operand is NaN if exponent is all-ones and mantissa is non-zero.
  - Any NaN gives out_unord=1 and out_lt=out_eq=out_gt=0.
  - out_res=1 only for NE; GT/GE/LT/LE/EQ give 0.
  - MAX/MIN return the non-NaN operand; if both are NaN, return in_a with out_res=1.
- When undefined:
  - NaN patterns compare as ordinary sign-magnitude values.
  - out_unord is tied to 0.

Test Plan:
- Default widths, out_ready=1.
  - A=0x40000000 (2.0), B=0x3F800000 (1.0), op=GT, tag=3 -> 2 cycles later: gt=1, res=1, tag=3.
  - Back-to-back: next cycle A=0xBF800000, B=0xC0000000, op=LT -> lt=0, gt=1, res=0 (-1 > -2).
- A=0x00000000, B=0x80000000, op=EQ -> eq=1, res=1. Same pair with op=MIN -> out_sel=0x00000000, res=1.
- A=0xBF800000, B=0x3F800000, op=MAX -> out_sel=0x3F800000, res=0, lt=1.
- Backpressure: stream 4 compares with tags 0..3 while out_ready=0 -> accepts exactly 2, then in_ready=0 and outputs stay stable. Raise out_ready -> tags 0,1,2,3 emerge in order on consecutive cycles, none lost or duplicated.
- FP_CMP_NAN_EN defined, A=0x7FC00000, B=0x3F800000:
  - op=NE -> unord=1, res=1.
  - op=GE -> res=0.
  - op=MAX -> out_sel=0x3F800000.
  - Without macro, op=GT -> gt=1.
- Assert rst_n=0 with 2 results in flight -> out_valid=0 immediately. After release, no stale results appear; the first new compare arrives after 2 cycles.

Source files
------------

// File: rtl/fp_compare_pipe_if.sv
// Handshake and operand bus for fp_compare_pipe: request side (in_*) and result side (out_*).
interface fp_compare_pipe_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned TAG_W = 4
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic             out_lt;
   logic             out_eq;
   logic             out_gt;
   logic             out_res;
   logic [W-1:0]     out_sel;
   logic             out_unord;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_lt, out_eq, out_gt, out_res, out_sel, out_unord, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_lt, out_eq, out_gt, out_res, out_sel, out_unord, out_tag
   );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined sign-magnitude floating-point comparator with valid/ready backpressure.
// Define FP_CMP_NAN_EN to treat NaN operands as unordered.
module fp_compare_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   fp_compare_pipe_if.slave  bus
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   typedef enum logic [2:0] {
      OpGt, OpGe, OpLt, OpLe, OpEq, OpNe, OpMax, OpMin
   } op_e;

   logic             s1_valid, s2_valid;
   logic             s2_adv;
   logic [W-1:0]     s1_a, s1_b;
   op_e              s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_mag_gt, s1_mag_eq, s1_zero_a, s1_zero_b;

   logic             lt_c, eq_c, gt_c, res_c, sel_a_c;
   logic             out_lt, out_eq, out_gt, out_res;
   logic [W-1:0]     out_sel;
   logic [TAG_W-1:0] out_tag;

   assign s2_adv       = ~s2_valid | bus.out_ready;
   assign bus.in_ready = ~s1_valid | s2_adv;

   // Stage 1: magnitude compare ignoring the sign bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= OpGt;
         s1_tag    <= '0;
         s1_mag_gt <= 1'b0;
         s1_mag_eq <= 1'b0;
         s1_zero_a <= 1'b0;
         s1_zero_b <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_a      <= bus.in_a;
            s1_b      <= bus.in_b;
            s1_op     <= op_e'(bus.in_op);
            s1_tag    <= bus.in_tag;
            s1_mag_gt <= bus.in_a[W-2:0] > bus.in_b[W-2:0];
            s1_mag_eq <= bus.in_a[W-2:0] == bus.in_b[W-2:0];
            s1_zero_a <= bus.in_a[W-2:0] == '0;
            s1_zero_b <= bus.in_b[W-2:0] == '0;
         end
      end
   end

`ifdef FP_CMP_NAN_EN
   logic s1_nan_a, s1_nan_b, unord_c, out_unord;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_nan_a <= 1'b0;
         s1_nan_b <= 1'b0;
      end else if (bus.in_ready && bus.in_valid) begin
         s1_nan_a <= (&bus.in_a[W-2:MAN_W]) && (|bus.in_a[MAN_W-1:0]);
         s1_nan_b <= (&bus.in_b[W-2:MAN_W]) && (|bus.in_b[MAN_W-1:0]);
      end
   end

   assign unord_c = s1_nan_a | s1_nan_b;
`endif

   always_comb begin
      lt_c    = 1'b0;
      eq_c    = 1'b0;
      gt_c    = 1'b0;
      res_c   = 1'b0;
      sel_a_c = 1'b0;
      if (s1_zero_a && s1_zero_b) begin
         eq_c = 1'b1;
      end else if (s1_a[W-1] != s1_b[W-1]) begin
         gt_c = ~s1_a[W-1];
      end else if (!s1_a[W-1]) begin
         gt_c = s1_mag_gt;
         eq_c = s1_mag_eq;
      end else begin
         gt_c = ~s1_mag_gt & ~s1_mag_eq;
         eq_c = s1_mag_eq;
      end
      lt_c = ~gt_c & ~eq_c;
`ifdef FP_CMP_NAN_EN
      if (unord_c) begin
         lt_c = 1'b0;
         eq_c = 1'b0;
         gt_c = 1'b0;
      end
`endif
      unique case (s1_op)
         OpGt:    res_c = gt_c;
         OpGe:    res_c = gt_c | eq_c;
         OpLt:    res_c = lt_c;
         OpLe:    res_c = lt_c | eq_c;
         OpEq:    res_c = eq_c;
         OpNe:    res_c = ~eq_c;
         OpMax:   sel_a_c = gt_c | eq_c;
         OpMin:   sel_a_c = lt_c | eq_c;
         default: res_c = 1'b0;
      endcase
`ifdef FP_CMP_NAN_EN
      // Prefer the non-NaN operand; two NaNs fall back to A.
      if (unord_c) sel_a_c = s1_nan_b;
`endif
      if (s1_op == OpMax || s1_op == OpMin) res_c = sel_a_c;
   end

   // Stage 2: registered results, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_lt   <= 1'b0;
         out_eq   <= 1'b0;
         out_gt   <= 1'b0;
         out_res  <= 1'b0;
         out_sel  <= '0;
         out_tag  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_lt  <= lt_c;
            out_eq  <= eq_c;
            out_gt  <= gt_c;
            out_res <= res_c;
            out_sel <= ((s1_op == OpMax || s1_op == OpMin) && !sel_a_c) ? s1_b : s1_a;
            out_tag <= s1_tag;
         end
      end
   end

`ifdef FP_CMP_NAN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    out_unord <= 1'b0;
      else if (s2_adv && s1_valid)   out_unord <= unord_c;
   end
   assign bus.out_unord = out_unord;
`else
   assign bus.out_unord = 1'b0;
`endif

   assign bus.out_valid = s2_valid;
   assign bus.out_lt    = out_lt;
   assign bus.out_eq    = out_eq;
   assign bus.out_gt    = out_gt;
   assign bus.out_res   = out_res;
   assign bus.out_sel   = out_sel;
   assign bus.out_tag   = out_tag;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: directed vectors in, monitor pops and compares results.
module tb_fp_compare_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_compare_pipe_if bus ();
   fp_compare_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic lt, eq, gt, res, unord;
      logic [31:0] sel;
      logic [3:0]  tag;
   } res_t;
   typedef struct {
      res_t v;
      int   acc;
      bit   lat;
   } sb_t;

   localparam logic [2:0] GT = 3'd0, GE = 3'd1, LT = 3'd2, LE = 3'd3;
   localparam logic [2:0] EQ = 3'd4, NE = 3'd5, MAX = 3'd6, MIN = 3'd7;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   sb_t  sbq[$];
   int   pop_cyc[$];
   res_t act;
   sb_t  ent;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] req);
      checks++;
      if (actual !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, actual, req);
      end
   endtask

   function automatic res_t mk(input logic lt, eq, gt, res, unord, input logic [31:0] sel,
                               input logic [3:0] tag);
      mk = '{lt: lt, eq: eq, gt: gt, res: res, unord: unord, sel: sel, tag: tag};
   endfunction

   // Monitor: a transfer happens at the posedge following this sample point.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.out_valid && bus.out_ready) begin
            act = '{lt: bus.out_lt, eq: bus.out_eq, gt: bus.out_gt, res: bus.out_res,
                    unord: bus.out_unord, sel: bus.out_sel, tag: bus.out_tag};
            pop_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%h required=none", act);
            end else begin
               ent = sbq.pop_front();
               check($sformatf("result_tag%0d", ent.v.tag), 64'(act), 64'(ent.v));
               if (ent.lat) check("latency", 64'(cyc - ent.acc), 64'd2);
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, b, input logic [2:0] op, input logic [3:0] tag,
                       input res_t e, input bit push, input bit lat);
      sb_t s;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_tag   = tag;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (bus.in_ready) begin
            if (push) begin
               s.v = e;
               s.acc = cyc;
               s.lat = lat;
               sbq.push_back(s);
            end
            @(posedge clk);
            return;
         end
         @(negedge clk);
      end
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept tag=%0d", tag);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #3;
         if (sbq.size() == 0 && !bus.out_valid) return;
      end
      check("drain_timeout", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int start;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      check("reset_valid", 64'(bus.out_valid), 64'd0);
      check("reset_flags", 64'({bus.out_lt, bus.out_eq, bus.out_gt, bus.out_res, bus.out_unord}),
            64'd0);
      check("reset_sel_tag", 64'({bus.out_sel, bus.out_tag}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("ready_after_reset", 64'(bus.in_ready), 64'd1);

      // Back-to-back ordering with latency tracking
      send(32'h40000000, 32'h3F800000, GT, 4'd3, mk(0, 0, 1, 1, 0, 32'h40000000, 3), 1, 1);
      send(32'hBF800000, 32'hC0000000, LT, 4'd4, mk(0, 0, 1, 0, 0, 32'hBF800000, 4), 1, 1);
      send(32'h00000000, 32'h80000000, EQ, 4'd5, mk(0, 1, 0, 1, 0, 32'h00000000, 5), 1, 1);
      send(32'h00000000, 32'h80000000, MIN, 4'd6, mk(0, 1, 0, 1, 0, 32'h00000000, 6), 1, 1);
      send(32'hBF800000, 32'h3F800000, MAX, 4'd7, mk(1, 0, 0, 0, 0, 32'h3F800000, 7), 1, 1);
      send(32'h3F800000, 32'h3F800000, GE, 4'd8, mk(0, 1, 0, 1, 0, 32'h3F800000, 8), 1, 1);
      send(32'h3F800000, 32'h40000000, LE, 4'd9, mk(1, 0, 0, 1, 0, 32'h3F800000, 9), 1, 1);
      send(32'h3F800000, 32'h3F800000, NE, 4'd10, mk(0, 1, 0, 0, 0, 32'h3F800000, 10), 1, 1);
      // Infinity above max finite; positive denormal above negative denormal
      send(32'h7F800000, 32'h7F7FFFFF, GT, 4'd1, mk(0, 0, 1, 1, 0, 32'h7F800000, 1), 1, 1);
      send(32'h00000001, 32'h80000002, GT, 4'd2, mk(0, 0, 1, 1, 0, 32'h00000001, 2), 1, 1);
      send(32'h00000002, 32'h00000001, MIN, 4'd11, mk(0, 0, 1, 0, 0, 32'h00000001, 11), 1, 1);
      send(32'hC0000000, 32'hBF800000, MAX, 4'd12, mk(1, 0, 0, 0, 0, 32'hBF800000, 12), 1, 1);
      idle();
      drain();

      // Backpressure: two accepts fill the pipe, then stall
      bus.out_ready = 1'b0;
      send(32'h40000000, 32'h3F800000, GT, 4'd0, mk(0, 0, 1, 1, 0, 32'h40000000, 0), 1, 0);
      send(32'h3F800000, 32'h40000000, LT, 4'd1, mk(1, 0, 0, 1, 0, 32'h3F800000, 1), 1, 0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h3F800000;
      bus.in_b     = 32'h3F800000;
      bus.in_op    = EQ;
      bus.in_tag   = 4'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         #1;
         check("stall_hold", 64'({bus.out_valid, bus.out_gt, bus.out_res, bus.out_sel, bus.out_tag}),
               64'({1'b1, 1'b1, 1'b1, 32'h40000000, 4'd0}));
         @(negedge clk);
      end
      start = pop_cyc.size();
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", 64'(bus.in_ready), 64'd1);
      ent.v   = mk(0, 1, 0, 1, 0, 32'h3F800000, 2);
      ent.acc = cyc;
      ent.lat = 0;
      sbq.push_back(ent);
      @(posedge clk);
      send(32'hBF800000, 32'h3F800000, MIN, 4'd3, mk(1, 0, 0, 1, 0, 32'hBF800000, 3), 1, 0);
      idle();
      drain();
      check("bp_pop_count", 64'(pop_cyc.size() - start), 64'd4);
      if (pop_cyc.size() - start == 4) begin
         for (int i = 0; i < 3; i++)
            check("bp_consecutive", 64'(pop_cyc[start+i+1] - pop_cyc[start+i]), 64'd1);
      end

      // Reset with two results in flight
      bus.out_ready = 1'b0;
      send(32'h40000000, 32'h3F800000, GT, 4'd13, mk(0, 0, 1, 1, 0, 32'h40000000, 13), 0, 0);
      send(32'h40000000, 32'h3F800000, GT, 4'd14, mk(0, 0, 1, 1, 0, 32'h40000000, 14), 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_kill_valid", 64'(bus.out_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         check("no_stale_output", 64'(bus.out_valid), 64'd0);
      end
      send(32'h3F800000, 32'h40000000, LT, 4'd15, mk(1, 0, 0, 1, 0, 32'h3F800000, 15), 1, 1);
      idle();
      drain();

      // NaN operand handling
`ifdef FP_CMP_NAN_EN
      send(32'h7FC00000, 32'h3F800000, NE, 4'd4, mk(0, 0, 0, 1, 1, 32'h7FC00000, 4), 1, 1);
      send(32'h7FC00000, 32'h3F800000, GE, 4'd5, mk(0, 0, 0, 0, 1, 32'h7FC00000, 5), 1, 1);
      send(32'h7FC00000, 32'h3F800000, MAX, 4'd6, mk(0, 0, 0, 0, 1, 32'h3F800000, 6), 1, 1);
      send(32'h7FC00000, 32'h3F800000, GT, 4'd7, mk(0, 0, 0, 0, 1, 32'h7FC00000, 7), 1, 1);
      send(32'h7FC00000, 32'h7FC00001, MAX, 4'd8, mk(0, 0, 0, 1, 1, 32'h7FC00000, 8), 1, 1);
      send(32'h3F800000, 32'hFFC00000, MIN, 4'd9, mk(0, 0, 0, 1, 1, 32'h3F800000, 9), 1, 1);
`else
      send(32'h7FC00000, 32'h3F800000, NE, 4'd4, mk(0, 0, 1, 1, 0, 32'h7FC00000, 4), 1, 1);
      send(32'h7FC00000, 32'h3F800000, GE, 4'd5, mk(0, 0, 1, 1, 0, 32'h7FC00000, 5), 1, 1);
      send(32'h7FC00000, 32'h3F800000, MAX, 4'd6, mk(0, 0, 1, 1, 0, 32'h7FC00000, 6), 1, 1);
      send(32'h7FC00000, 32'h3F800000, GT, 4'd7, mk(0, 0, 1, 1, 0, 32'h7FC00000, 7), 1, 1);
      send(32'h7FC00000, 32'h7FC00001, MAX, 4'd8, mk(1, 0, 0, 0, 0, 32'h7FC00001, 8), 1, 1);
      send(32'h3F800000, 32'hFFC00000, MIN, 4'd9, mk(0, 0, 1, 0, 0, 32'hFFC00000, 9), 1, 1);
`endif
      idle();
      drain();

      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
